// File: rtl/mdu_sched.sv
// mdu_sched: one-at-a-time scheduler for the external pipelined multiplier and iterative divider,
// with result buffering, divide bypass for zero/overflow cases and flush draining.
module mdu_sched #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        mul_valid,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_valid,
    input  logic        div_ready,
    output logic        div_signed,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_out_valid,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);
    typedef enum logic [2:0] {IDLE, MUL, DIV_REQ, DIV_WAIT, RESP, DRAIN} state_t;
    state_t      state;
    logic [31:0] a_r, b_r;
    logic        sgn_r, lo_r, rem_r;
    logic [2:0]  cnt;
    logic        acc, is_mul, is_div, sgn, rem, dz, ovf;
    assign req_ready    = resetn && state == IDLE && !flush;
    assign acc          = req_valid && req_ready;
    assign is_mul       = |req_op[2:0];
    assign is_div       = |req_op[6:3];
    assign sgn          = req_op[0] | req_op[1] | req_op[3] | req_op[5];
    assign rem          = req_op[5] | req_op[6];
    assign dz           = req_src2 == 32'd0;
    assign ovf          = sgn && req_src1 == 32'h8000_0000 && req_src2 == 32'hFFFF_FFFF;
    assign resp_valid   = state == RESP;
    assign mul_signed   = sgn_r;
    assign mul_a        = a_r;
    assign mul_b        = b_r;
    assign div_signed   = sgn_r;
    assign div_dividend = a_r;
    assign div_divisor  = b_r;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            sgn_r       <= 1'b0;
            lo_r        <= 1'b0;
            rem_r       <= 1'b0;
            cnt         <= 3'd0;
            resp_result <= 32'd0;
            mul_valid   <= 1'b0;
            div_valid   <= 1'b0;
        end else begin
            mul_valid <= 1'b0;
            case (state)
                IDLE: if (acc) begin
                    a_r   <= req_src1;
                    b_r   <= req_src2;
                    sgn_r <= sgn;
                    lo_r  <= req_op[0];
                    rem_r <= rem;
                    if (is_mul) begin
                        state     <= MUL;
                        mul_valid <= 1'b1;
                        cnt       <= 3'(MUL_LAT);
                    end else if (is_div && (dz || ovf)) begin
                        state       <= RESP;
                        resp_result <= dz ? (rem ? req_src1 : 32'd0) : (rem ? 32'd0 : 32'h8000_0000);
                    end else if (is_div) begin
                        state     <= DIV_REQ;
                        div_valid <= 1'b1;
                    end
                end
                MUL: if (flush) begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end else if (cnt == 3'd0) begin
                    state       <= RESP;
                    resp_result <= lo_r ? mul_result[31:0] : mul_result[63:32];
                end else begin
                    cnt <= cnt - 3'd1;
                end
                DIV_REQ: if (flush || div_ready) begin
                    div_valid <= 1'b0;
                    state     <= flush ? (div_ready ? DRAIN : IDLE) : DIV_WAIT;
                end
                // a result landing in the flush cycle is dropped, so nothing is left to drain
                DIV_WAIT: if (div_out_valid) begin
                    state <= flush ? IDLE : RESP;
                    if (!flush) resp_result <= rem_r ? div_remainder : div_quotient;
                end else if (flush) begin
                    state <= DRAIN;
                end
                RESP: if (flush || resp_ready) state <= IDLE;
                DRAIN: if (div_out_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Scheduler and controller for the multi-cycle multiply/divide resources behind the EX-stage ALU.
- Accepts one mul/div operation at a time from EX through a valid/ready handshake.
- Issues the operation to an external fixed-latency pipelined multiplier or an external variable-latency iterative divider, selects and buffers the 32-bit result, and returns it through a valid/ready response.
- Handles pipeline flush mid-operation, including draining a divider that cannot be aborted.

Parameters:
MUL_LAT, 1, fixed multiplier latency in cycles from mul_valid to mul_result valid (1..4)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
flush  in  1  cancel the in-flight operation (exception/branch flush)
req_valid  in  1  EX request valid
req_ready  out  1  scheduler can accept a request
req_op  in  7  one-hot: [0]mul [1]mulh [2]mulhu [3]div [4]divu [5]mod [6]modu
req_src1  in  32  rj operand
req_src2  in  32  rk operand
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_result  out  32  selected result
mul_valid  out  1  one-cycle issue pulse to multiplier
mul_signed  out  1  1 = signed multiply
mul_a  out  32  multiplicand
mul_b  out  32  multiplier
mul_result  in  64  product, valid exactly MUL_LAT cycles after mul_valid
div_valid  out  1  divider request
div_ready  in  1  divider accepts request
div_signed  out  1  1 = signed divide
div_dividend  out  32  dividend
div_divisor  out  32  divisor
div_out_valid  in  1  one-cycle pulse: quotient/remainder valid
div_quotient  in  32  quotient
div_remainder  in  32  remainder

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready=0 during reset, 1 in the first cycle after reset.
  - resp_valid=0, mul_valid=0, div_valid=0.
  - resp_result, mul_a/b, div_dividend/divisor = 0.
- States: IDLE, MUL, DIV_REQ, DIV_WAIT, RESP, DRAIN.
- req_ready = (state==IDLE) & ~flush. Acceptance at cycle T = req_valid & req_ready.
  - Operands, op and the signed flag are registered at T.
- Signed flag: mul, mulh, div and mod are signed; mulhu, divu and modu are unsigned.
- IDLE -> MUL when the op is mul/mulh/mulhu:
  - mul_valid=1 in T+1 only.
  - A counter loaded with MUL_LAT decrements each cycle.
  - mul_result is captured at T+1+MUL_LAT.
  - Result is mul_result[31:0] for mul and mul_result[63:32] for mulh/mulhu.
  - -> RESP, so resp_valid is asserted from T+2+MUL_LAT.
- IDLE -> DIV_REQ for div/divu/mod/modu, except the bypass cases below:
  - div_valid=1 with stable operands until div_ready. The handshake cycle -> DIV_WAIT, and div_valid drops the next cycle.
  - In DIV_WAIT, div_out_valid captures the quotient (div/divu) or remainder (mod/modu) -> RESP.
- Bypass: no divider issue; the result is registered at T; -> RESP, so resp_valid=1 at T+1.
  - Divisor zero, any div/mod op: quotient 0x00000000, remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, div or mod): quotient 0x80000000, remainder 0.
- RESP: resp_valid=1 and resp_result stable until resp_ready. On handshake -> IDLE.
  - No new acceptance in the same cycle as the response handshake, so back-to-back ops are spaced by at least one IDLE cycle.
- Flush, taking effect in the cycle it is sampled:
  - IDLE: nothing is accepted.
  - MUL: -> IDLE; the pending mul_result is ignored and the counter is cleared.
  - DIV_REQ with no handshake this cycle: -> IDLE and div_valid drops (the divider contract allows withdrawal before acceptance).
  - DIV_REQ with handshake this same cycle: -> DRAIN.
  - DIV_WAIT: -> DRAIN. If div_out_valid arrives the same cycle, it is discarded and the block goes -> IDLE instead.
  - DRAIN: req_ready=0; wait for div_out_valid, discard it, -> IDLE.
  - RESP: resp_valid drops the next cycle; -> IDLE; the result is lost.
  - Flush while already in DRAIN has no further effect.
- Reset mid-operation forces IDLE immediately.
  - The divider is reset by the same resetn, so no drain is needed.
- mul_valid and div_valid are never asserted simultaneously.
- At most one operation is outstanding at any time.
- Precondition: req_op is exactly one-hot whenever req_valid=1. The bench asserts this; RTL behaviour otherwise is unspecified.

Test Plan:
- mulh 0xFFFFFFFE × 0x00000003 (signed), MUL_LAT=1, resp_ready=1 → mul_valid at T+1 with mul_signed=1; resp_valid at T+3 with resp_result 0xFFFFFFFF. Then mulhu with the same operands → 0x00000002.
- divu 100 / 7 with the divider model delaying div_ready 2 cycles and div_out_valid 10 cycles → div_valid held stable for 3 cycles, resp_result 14. modu with the same operands → 2.
- div 0x12345678 / 0 → no div_valid; resp_valid at T+1 with 0. mod with the same operands → 0x12345678. div 0x80000000 / 0xFFFFFFFF → 0x80000000.
- resp_ready held low 5 cycles after a mul result → resp_valid and resp_result stable, req_ready=0 throughout; handshake → IDLE and req_ready=1 the next cycle.
- Flush 3 cycles into DIV_WAIT → DRAIN with req_ready=0; a late div_out_valid is discarded with no resp_valid; the next mul is accepted and correct.
- Flush in DIV_REQ before div_ready → div_valid drops the next cycle and state is IDLE. resetn low during MUL → all outputs at reset values the next cycle.
